// File: rtl/cache_line_filler_pkg.sv
// Shared cache package: refill FSM state encoding and default line geometry.
// Used by the line filler and by the cache top so both agree on layout.
package cache_line_filler_pkg;

  // Refill FSM state type and encodings.
  typedef logic [1:0] fill_state_t;

  localparam fill_state_t ST_INIT = 2'd0;  // post-reset clear sweep
  localparam fill_state_t ST_IDLE = 2'd1;  // waiting for a refill request
  localparam fill_state_t ST_FILL = 2'd2;  // accepting refill beats
  localparam fill_state_t ST_DONE = 2'd3;  // one-cycle completion pulse

  // Default line geometry.
  localparam int DEF_INDEX_WIDTH    = 7;
  localparam int DEF_WORDS_PER_LINE = 8;
  localparam int DEF_DATA_WIDTH     = 32;

endpackage

// File: rtl/cache_line_filler.sv
// Cache line filler: clears the data RAM after reset, then writes refill
// bursts into one set at a time through RAM port A with zero latency.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. Ready depends only on FSM state, never on valid. The source
// holds valid and payload until the transfer edge.
module cache_line_filler
  import cache_line_filler_pkg::*;
#(
  parameter  int INDEX_WIDTH    = DEF_INDEX_WIDTH,
  parameter  int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter  int DATA_WIDTH     = DEF_DATA_WIDTH,
  localparam int OFF_WIDTH      = $clog2(WORDS_PER_LINE),
  localparam int ADDR_WIDTH     = INDEX_WIDTH + OFF_WIDTH
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [INDEX_WIDTH-1:0] req_index,
  input  logic                   beat_valid,
  output logic                   beat_ready,
  input  logic [DATA_WIDTH-1:0]  beat_data,
  input  logic                   beat_last,
  output logic                   ram_ena,
  output logic                   ram_wea,
  output logic [ADDR_WIDTH-1:0]  ram_addra,
  output logic [DATA_WIDTH-1:0]  ram_dina,
  output logic [INDEX_WIDTH-1:0] busy_index,
  output logic                   fill_busy,
  output logic                   init_done,
  output logic                   fill_done,
  output logic                   fill_err,
  output fill_state_t            dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] SWEEP_LAST = '1;
  localparam logic [OFF_WIDTH-1:0]  LINE_LAST  = OFF_WIDTH'(WORDS_PER_LINE - 1);

  fill_state_t            r_state;
  logic [ADDR_WIDTH-1:0]  r_sweep;
  logic [OFF_WIDTH-1:0]   r_cnt;
  logic [INDEX_WIDTH-1:0] r_busy_index;
  logic                   r_init_done;
  logic                   r_fill_err;

  logic w_sweep_wr;
  logic w_beat_hs;
  logic w_line_end;

  // The sweep write is gated by resetn so the port stays quiet while reset
  // is held, yet the first write lands on the first edge after release.
  assign w_sweep_wr = (r_state == ST_INIT) && resetn;
  assign w_beat_hs  = (r_state == ST_FILL) && beat_valid;
  assign w_line_end = (r_cnt == LINE_LAST);

  // FSM, sweep counter, beat counter and captured request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_INIT;
      r_sweep      <= '0;
      r_cnt        <= '0;
      r_busy_index <= '0;
      r_init_done  <= 1'b0;
      r_fill_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_sweep == SWEEP_LAST) begin
            r_state     <= ST_IDLE;
            r_init_done <= 1'b1;
            r_sweep     <= '0;
          end else begin
            r_sweep <= r_sweep + ADDR_WIDTH'(1);
          end
        end
        ST_IDLE: begin
          r_fill_err <= 1'b0;
          if (req_valid) begin
            r_busy_index <= req_index;
            r_cnt        <= '0;
            r_state      <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (beat_valid) begin
            r_cnt <= r_cnt + OFF_WIDTH'(1);
            // The line ends on its last word or on an early last flag;
            // only a last flag exactly on the last word is error-free.
            if (w_line_end || beat_last) begin
              r_state    <= ST_DONE;
              r_fill_err <= !(w_line_end && beat_last);
            end
          end
        end
        ST_DONE: begin
          r_state    <= ST_IDLE;
          r_fill_err <= 1'b0;
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  // RAM port A: sweep zeros in INIT, pass beats through on handshakes.
  always_comb begin
    ram_ena   = 1'b0;
    ram_wea   = 1'b0;
    ram_addra = '0;
    ram_dina  = '0;
    if (w_sweep_wr) begin
      ram_ena   = 1'b1;
      ram_wea   = 1'b1;
      ram_addra = r_sweep;
    end else if (w_beat_hs) begin
      ram_ena   = 1'b1;
      ram_wea   = 1'b1;
      ram_addra = {r_busy_index, r_cnt};
      ram_dina  = beat_data;
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign beat_ready = (r_state == ST_FILL);
  assign fill_busy  = (r_state == ST_FILL) || (r_state == ST_DONE);
  assign fill_done  = (r_state == ST_DONE);
  assign fill_err   = r_fill_err && (r_state == ST_DONE);
  assign init_done  = r_init_done;
  assign busy_index = r_busy_index;
  assign dbg_state  = r_state;

endmodule

// File: doc/cache_line_filler.md
CACHE_LINE_FILLER -- requirements
Module: cache_line_filler

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 7, meaning set-index bits.
REQ-002 SHALL have parameter WORDS_PER_LINE, default 8, meaning words per line; power of two, at least 2.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning word width.
REQ-004 SHALL have localparam OFF_WIDTH = $clog2(WORDS_PER_LINE) and localparam ADDR_WIDTH = INDEX_WIDTH+OFF_WIDTH.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port resetn, input, 1, meaning the reset: asynchronous and active-low.
REQ-007 SHALL have port req_valid / req_ready, input / output, 1 each, meaning the refill-request handshake.
REQ-008 SHALL have port req_index, input, INDEX_WIDTH, meaning the set to refill.
REQ-009 SHALL have port beat_valid / beat_ready, input / output, 1 each, meaning the refill-data handshake.
REQ-010 SHALL have port beat_data, input, DATA_WIDTH, meaning one refill word.
REQ-011 SHALL have port beat_last, input, 1, meaning final beat of the burst.
REQ-012 SHALL have port ram_ena and ram_wea, outputs, 1 each, meaning write-port enables to the data RAM.
REQ-013 SHALL have port ram_addra, output, ADDR_WIDTH, meaning write address {index, offset}.
REQ-014 SHALL have port ram_dina, output, DATA_WIDTH, meaning write data.
REQ-015 SHALL have port busy_index, output, INDEX_WIDTH, meaning the set currently being filled.
REQ-016 SHALL have port fill_busy, output, 1, meaning busy_index holds partial data; the cache blocks reads to that set.
REQ-017 SHALL have port init_done, output, 1, meaning the post-reset clear sweep is complete.
REQ-018 SHALL have ports fill_done and fill_err, outputs, 1 each, meaning one-cycle completion pulse and burst-length error.

Function
REQ-019 SHALL implement states INIT, IDLE, FILL and DONE.
REQ-020 INIT SHALL drive ram_ena=ram_wea=1, ram_dina=0 and ram_addra=sweep counter each cycle, counter 0 to 2^ADDR_WIDTH-1, one address per cycle.
REQ-021 INIT SHALL then go to IDLE and set init_done=1, holding it until reset.
REQ-022 req_ready SHALL be 1 only in IDLE.
REQ-023 A req handshake SHALL register req_index into busy_index, clear the beat counter and go to FILL.
REQ-024 beat_ready SHALL be 1 only in FILL.
REQ-025 Each beat handshake SHALL drive, in the same cycle and combinationally, ram_ena=ram_wea=1, ram_addra={busy_index, counter}, ram_dina=beat_data; the counter increments by 1.
REQ-026 Zero-latency write SHALL hold: the word is in the RAM at the handshake clock edge.
REQ-027 Outside INIT and beat handshakes, ram_ena and ram_wea SHALL be 0, and ram_addra/ram_dina SHALL be don't-care, driven 0.
REQ-028 The beat at counter=WORDS_PER_LINE-1 SHALL end FILL and go to DONE whatever the value of beat_last; fill_err is set if beat_last=0.
REQ-029 beat_last=1 at counter<WORDS_PER_LINE-1 SHALL write that beat, end FILL, go to DONE and set fill_err=1; unwritten words keep old contents.
REQ-030 DONE SHALL last exactly one cycle with fill_done=1, fill_err valid, then return to IDLE.
REQ-031 fill_err SHALL be 0 whenever fill_done=0.
REQ-032 fill_busy SHALL be 1 in FILL and DONE, and 0 otherwise.
REQ-033 beat_valid outside FILL SHALL be ignored (no write), and the beat SHALL not be consumed.
REQ-034 req_valid SHALL be held off during INIT; a new request SHALL be accepted at the earliest in the IDLE cycle after DONE (two-cycle minimum gap between the last beat and the next req handshake).

Reset
REQ-035 resetn=0 SHALL asynchronously force: state INIT, all counters 0, busy_index 0, init_done, fill_busy, fill_done, fill_err, req_ready, beat_ready, ram_ena and ram_wea all 0.
REQ-036 Reset mid-FILL SHALL abandon the burst with no done pulse, and the full clear sweep SHALL rerun.
REQ-037 The first sweep write SHALL occur in the first clk cycle after resetn deasserts.

Structure
REQ-038 Refill state enum and the line geometry constants SHALL live in the shared cache package, used alike by this block and the cache top.
REQ-039 The block SHALL be flat, with no sub-module; it connects to port A of the existing simple dual-port RAM wrapper.

Verification
REQ-040 Reset release with INDEX_WIDTH=2, WORDS_PER_LINE=4 -> 16 consecutive zero writes at addresses 0..15, then init_done=1 at cycle 17.
REQ-041 req_index=5 and 8 back-to-back beats 0xA0..0xA7 with last on the 8th -> writes at 0x28..0x2F, fill_done pulses one cycle, fill_err=0.
REQ-042 beat_last on the 3rd beat for index 1 -> 3 writes at 0x08..0x0A, fill_done=1 with fill_err=1, and words 0x0B..0x0F unchanged.
REQ-043 Beats with gaps (beat_valid toggling every cycle) -> writes only on handshake cycles, with the correct incrementing offsets.
REQ-044 resetn pulsed after 4 beats of a fill -> no fill_done, the sweep restarts from address 0, and those 4 words read 0 afterwards.
REQ-045 req_valid held high through INIT and through a fill -> req accepted only in IDLE, and the next req handshake comes no earlier than 2 cycles after the final beat.
